// File: rtl/agc_sar_gain_ctrl.sv
// agc_sar_gain_ctrl: MSB-first successive-approximation AGC gain search with a settle window and lock flag.
// Define AGC_TRACK_EN to keep tracking +/-1 LSB after lock; without it, lock is terminal until reset.
module agc_sar_gain_ctrl #(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             restart,
  input  logic             adjust,
  input  logic             up_dn,
  output logic             ready,
  output logic [WIDTH-1:0] gain,
  output logic             done,
  output logic             done_pulse
);

  localparam int PTR_W   = $clog2(WIDTH);
  localparam int CNT_RAW = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] GAIN_INIT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PTR_W-1:0] PTR_INIT   = PTR_W'(WIDTH - 1);
  localparam bit               HAS_SETTLE = (SETTLE_CYCLES != 0);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] gain_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             done_q;
  logic             done_pulse_q;
  logic             ready_c;
  logic             accept;

  // Resolve trial bit k from the decision and arm bit k-1 as the next trial bit.
  function automatic logic [WIDTH-1:0] sar_step(input logic [WIDTH-1:0] g,
                                                input logic [PTR_W-1:0] k,
                                                input logic             up);
    logic [WIDTH-1:0] r;
    r = g;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == int'(k)) r[i] = up;
      if (i + 1 == int'(k)) r[i] = 1'b1;
    end
    return r;
  endfunction

`ifdef AGC_TRACK_EN
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] g);
    return (g == {WIDTH{1'b1}}) ? g : g + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] g);
    return (g == {WIDTH{1'b0}}) ? g : g - 1'b1;
  endfunction
`endif

  // A decision arriving together with RESET or restart is dropped.
  assign accept = adjust & ready_c & ~restart & ~RESET;

  always_ff @(posedge clk) begin
    if (RESET || restart) state_q <= S_SEARCH;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH: begin
        // Without a settle window only the final decision needs a detour before lock.
        if (accept && (HAS_SETTLE || ptr_q == '0)) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q <= CNT_W'(1)) state_d = last_q ? S_DONE : S_SEARCH;
      end
      S_DONE: begin
`ifdef AGC_TRACK_EN
        if (accept && HAS_SETTLE) state_d = S_SETTLE;
`endif
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      S_SEARCH: ready_c = 1'b1;
      S_SETTLE: ready_c = 1'b0;
      S_DONE: begin
`ifdef AGC_TRACK_EN
        ready_c = 1'b1;
`else
        ready_c = 1'b0;
`endif
      end
      default: ready_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET || restart) begin
      gain_q       <= GAIN_INIT;
      ptr_q        <= PTR_INIT;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      if (accept && state_q == S_SEARCH) begin
        gain_q <= sar_step(gain_q, ptr_q, up_dn);
        if (ptr_q != '0) ptr_q  <= ptr_q - 1'b1;
        else             last_q <= 1'b1;
      end
`ifdef AGC_TRACK_EN
      if (accept && state_q == S_DONE) gain_q <= up_dn ? sat_inc(gain_q) : sat_dec(gain_q);
`endif
      if (accept)                                     cnt_q <= SETTLE_LD;
      else if (state_q == S_SETTLE && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
      // done latches on first lock; tracking settles return to DONE without a new strobe.
      done_q       <= done_q | (state_d == S_DONE);
      done_pulse_q <= (state_d == S_DONE) && !done_q;
    end
  end

  assign ready      = ready_c;
  assign gain       = gain_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;

endmodule
